// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and datapath mode selectors for gcd_stream.
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int MODE_SUB = 0;
  localparam int MODE_BIN = 1;
endpackage

// File: rtl/gcd_step.sv
// gcd_step: one combinational GCD iteration, subtractive or binary (Stein).
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = MODE_SUB
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] nx,
  output logic [WIDTH-1:0] ny,
  output logic             k_inc,
  output logic             eq
);
  localparam bit BIN = (MODE == MODE_BIN);
  logic gt;
  logic [WIDTH-1:0] dxy, dyx;
  assign eq  = (x == y);
  assign gt  = (x > y);
  assign dxy = x - y;
  assign dyx = y - x;
  // Stein priority: halve any even operand first, subtract only when both are odd
  always_comb begin
    k_inc = BIN && !x[0] && !y[0];
    nx    = BIN ? (!x[0] ? x >> 1 : (!y[0] || !gt ? x : dxy)) : (gt ? dxy : x);
    ny    = BIN ? (!y[0] ? y >> 1 : (!x[0] || gt ? y : dyx)) : (gt ? y : dyx);
  end
endmodule

// File: rtl/gcd_stream.sv
// gcd_stream: valid/ready GCD engine; IDLE/CALC/DONE FSM around a gcd_step datapath.
module gcd_stream
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = MODE_SUB
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic [WIDTH-1:0] out_iters,
  output logic             out_zero
);
  localparam int KW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] x, y, nx, ny, iters;
  logic [KW-1:0] k;
  logic k_inc, eq, accept;
  assign in_ready = reset_n && (state == IDLE || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  gcd_step #(.WIDTH(WIDTH), .MODE(MODE)) u_step (
    .x(x), .y(y), .nx(nx), .ny(ny), .k_inc(k_inc), .eq(eq)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      k         <= '0;
      iters     <= '0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_iters <= '0;
      out_zero  <= 1'b0;
    end else if (accept) begin
      x     <= in_a;
      y     <= in_b;
      k     <= '0;
      iters <= '0;
      // a zero operand makes the other one the answer, so skip CALC entirely
      if (in_a == '0 || in_b == '0) begin
        state     <= DONE;
        out_valid <= 1'b1;
        out_z     <= in_a | in_b;
        out_iters <= '0;
        out_zero  <= (in_a == '0) && (in_b == '0);
      end else begin
        state     <= CALC;
        out_valid <= 1'b0;
      end
    end else begin
      case (state)
        CALC: begin
          if (eq) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_z     <= x << k;
            out_iters <= iters;
            out_zero  <= 1'b0;
          end else begin
            x     <= nx;
            y     <= ny;
            k     <= k + KW'(k_inc);
            iters <= iters + WIDTH'(!(&iters));
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_stream.sv
// tb_gcd_stream: directed vector table, handshake corner sequences and a random scoreboard.
module tb_gcd_stream;
  logic clk = 1'b0;
  logic rst_n;
  logic iv[3], ir[3], ov[3], ordy[3], ozo[3];
  logic [15:0] ia[3], ib[3];
  logic [15:0] oz[2], oit[2];
  logic [7:0] oz8, oit8;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int m;
    logic [15:0] a, b, z, it;
    logic zero;
    int lat;
  } vec_t;
  typedef struct {
    logic [15:0] z;
    logic zero;
  } exp_t;

  always #5 clk = ~clk;

  gcd_stream #(.WIDTH(16), .MODE(0)) d0 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_z(oz[0]), .out_iters(oit[0]), .out_zero(ozo[0]));
  gcd_stream #(.WIDTH(16), .MODE(1)) d1 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_z(oz[1]), .out_iters(oit[1]), .out_zero(ozo[1]));
  gcd_stream #(.WIDTH(8), .MODE(0)) d2 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(ia[2][7:0]), .in_b(ib[2][7:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_z(oz8), .out_iters(oit8), .out_zero(ozo[2]));

  function automatic logic [15:0] zv(input int m);
    return m == 2 ? {8'h00, oz8} : oz[m];
  endfunction
  function automatic logic [15:0] itv(input int m);
    return m == 2 ? {8'h00, oit8} : oit[m];
  endfunction
  function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", n, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(input int m, input int lim, output int c);
    c = 1;
    while (!ov[m] && c < lim) begin
      tick();
      c++;
    end
  endtask

  task automatic run(input vec_t v, input string n);
    int c;
    ordy[v.m] = 1'b1;
    iv[v.m] = 1'b1;
    ia[v.m] = v.a;
    ib[v.m] = v.b;
    #1;
    c = 0;
    while (!ir[v.m] && c < 100) begin
      tick();
      c++;
    end
    chk({n, "_accept"}, ir[v.m], 1);
    tick();
    iv[v.m] = 1'b0;
    ia[v.m] = 16'($urandom);
    ib[v.m] = 16'($urandom);
    wait_ov(v.m, 1000, c);
    chk({n, "_latency"}, c, v.lat);
    chk({n, "_z"}, zv(v.m), v.z);
    chk({n, "_iters"}, itv(v.m), v.it);
    chk({n, "_zero"}, ozo[v.m], v.zero);
    tick();
  endtask

  task automatic rand_run(input int m, input int n);
    exp_t q[$];
    exp_t e;
    int sent = 0, got = 0, cyc = 0;
    bit taken = 0;
    iv[m] = 1'b0;
    while (got < n && cyc < 60000) begin
      tick();
      cyc++;
      if (taken) begin
        iv[m] = 1'b0;
        taken = 0;
      end
      if (!iv[m]) begin
        ia[m] = 16'($urandom);
        ib[m] = 16'($urandom);
        if (sent < n && $urandom_range(3) != 0) begin
          iv[m] = 1'b1;
          ia[m] = m == 0 ? 16'($urandom_range(255)) : ($urandom_range(15) == 0 ? 16'h0 : 16'($urandom));
          ib[m] = m == 0 ? 16'($urandom_range(255)) : ($urandom_range(15) == 0 ? 16'h0 : 16'($urandom));
        end
      end
      ordy[m] = $urandom_range(3) != 0;
      #1;
      if (iv[m] && ir[m]) begin
        q.push_back('{gcd_ref(ia[m], ib[m]), ia[m] == 0 && ib[m] == 0});
        sent++;
        taken = 1;
      end
      if (ov[m] && ordy[m]) begin
        if (q.size() == 0) begin
          chk($sformatf("rand_m%0d_extra", m), 1, 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("rand_m%0d_result%0d", m, got), {zv(m), ozo[m]}, {e.z, e.zero});
        end
        got++;
      end
    end
    iv[m] = 1'b0;
    chk($sformatf("rand_m%0d_count", m), got, n);
    chk($sformatf("rand_m%0d_pending", m), q.size(), 0);
  endtask

  vec_t tv[16];
  initial begin
    int c;
    tv[0]  = '{0, 48, 18, 6, 4, 0, 6};
    tv[1]  = '{1, 48, 18, 6, 6, 0, 8};
    tv[2]  = '{0, 0, 35, 35, 0, 0, 1};
    tv[3]  = '{1, 0, 35, 35, 0, 0, 1};
    tv[4]  = '{0, 0, 0, 0, 0, 1, 1};
    tv[5]  = '{1, 0, 0, 0, 0, 1, 1};
    tv[6]  = '{0, 35, 0, 35, 0, 0, 1};
    tv[7]  = '{0, 7, 7, 7, 0, 0, 2};
    tv[8]  = '{1, 12, 8, 4, 5, 0, 7};
    tv[9]  = '{0, 12, 8, 4, 2, 0, 4};
    tv[10] = '{1, 17, 5, 1, 7, 0, 9};
    tv[11] = '{0, 17, 5, 1, 6, 0, 8};
    tv[12] = '{2, 255, 1, 1, 254, 0, 256};
    tv[13] = '{1, 65535, 65535, 65535, 0, 0, 2};
    tv[14] = '{1, 32768, 16384, 16384, 15, 0, 17};
    tv[15] = '{2, 128, 64, 64, 1, 0, 3};
    for (int m = 0; m < 3; m++) begin
      iv[m] = 1'b0;
      ordy[m] = 1'b1;
      ia[m] = '0;
      ib[m] = '0;
    end
    rst_n = 1'b0;
    tick();
    tick();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("reset_m%0d", m), {ir[m], ov[m], zv(m), itv(m), ozo[m]}, 0);
    end
    rst_n = 1'b1;
    #1;
    for (int m = 0; m < 3; m++) chk($sformatf("reset_release_ready_m%0d", m), ir[m], 1);
    tick();

    for (int i = 0; i < 16; i++) run(tv[i], $sformatf("vec%0d", i));

    // backpressure on d0: result held, no accept, then same-cycle handoff
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    ia[0] = 12;
    ib[0] = 8;
    tick();
    iv[0] = 1'b0;
    wait_ov(0, 100, c);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_hold%0d", i), {ov[0], ir[0], oz[0]}, {1'b1, 1'b0, 16'd4});
      tick();
    end
    iv[0] = 1'b1;
    ia[0] = 9;
    ib[0] = 6;
    ordy[0] = 1'b1;
    #1;
    chk("bp_ready_same_cycle", ir[0], 1);
    tick();
    iv[0] = 1'b0;
    chk("bp_valid_drop", ov[0], 0);
    wait_ov(0, 100, c);
    chk("bp_next_z", oz[0], 3);
    tick();

    // zero-operand pair accepted from DONE keeps out_valid high
    ordy[1] = 1'b0;
    iv[1] = 1'b1;
    ia[1] = 6;
    ib[1] = 4;
    tick();
    iv[1] = 1'b0;
    wait_ov(1, 100, c);
    chk("zt_first_z", oz[1], 2);
    iv[1] = 1'b1;
    ia[1] = 0;
    ib[1] = 5;
    ordy[1] = 1'b1;
    tick();
    iv[1] = 1'b0;
    chk("zt_valid_held", {ov[1], oz[1], oit[1]}, {1'b1, 16'd5, 16'd0});
    tick();
    chk("zt_consumed", ov[1], 0);

    // reset in the middle of a long CALC
    iv[2] = 1'b1;
    ia[2] = 255;
    ib[2] = 1;
    tick();
    iv[2] = 1'b0;
    repeat (20) tick();
    chk("mid_calc_busy", {ov[2], ir[2]}, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_async", {ov[2], ir[2]}, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_reset_idle", {ov[2], ir[2]}, {1'b0, 1'b1});
    tick();
    run('{2, 10, 4, 2, 3, 0, 5}, "post_reset");

    fork
      rand_run(0, 1000);
      rand_run(1, 1000);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
